// File: rtl/cache_miss_ctrl.sv
// Miss controller for a 2-way LRU cache: lookup, dirty-victim writeback, line fill, replay.
// Optional hit/miss performance counters are enabled with the CACHE_MISS_PERF_EN macro.
module cache_miss_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic                          req_we,
  output logic                          resp_valid,
  output logic [ADDR_W-1:0]             lat_addr,
  output logic                          lat_we,
  output logic                          cache_lookup,
  input  logic                          cache_hit,
  input  logic                          cache_victim_dirty,
  input  logic [ADDR_W-1:0]             cache_victim_tag_addr,
  input  logic [31:0]                   cache_rd_word,
  output logic                          cache_fill_we,
  output logic [$clog2(LINE_WORDS)-1:0] cache_idx,
  output logic [31:0]                   cache_fill_data,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic                          mem_rvalid,
  input  logic [31:0]                   mem_rdata
`ifdef CACHE_MISS_PERF_EN
  ,
  output logic [31:0]                   hit_cnt,
  output logic [31:0]                   miss_cnt
`endif
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       lat_addr_q, lat_addr_d;
  logic                    lat_we_q, lat_we_d;
  logic [ADDR_W-1:OFF_W]   victim_line_q, victim_line_d;
  logic [IDX_W-1:0]        word_cnt_q, word_cnt_d;
  logic [IDX_W-1:0]        req_cnt_q, req_cnt_d;
  logic                    req_done_q, req_done_d;
  logic                    replay_q, replay_d;
`ifdef CACHE_MISS_PERF_EN
  logic [31:0]             hit_cnt_q, hit_cnt_d;
  logic [31:0]             miss_cnt_q, miss_cnt_d;
`endif

  logic unused_victim_offset;
  assign unused_victim_offset = ^cache_victim_tag_addr[OFF_W-1:0];

  assign lat_addr = lat_addr_q;
  assign lat_we   = lat_we_q;
`ifdef CACHE_MISS_PERF_EN
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  always_comb begin
    state_d         = state_q;
    lat_addr_d      = lat_addr_q;
    lat_we_d        = lat_we_q;
    victim_line_d   = victim_line_q;
    word_cnt_d      = word_cnt_q;
    req_cnt_d       = req_cnt_q;
    req_done_d      = req_done_q;
    replay_d        = replay_q;
`ifdef CACHE_MISS_PERF_EN
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;
`endif
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    cache_lookup    = 1'b0;
    cache_fill_we   = 1'b0;
    cache_idx       = '0;
    cache_fill_data = '0;
    mem_req_valid   = 1'b0;
    mem_req_we      = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;

    unique case (state_q)
      IDLE: begin
        // Held low while reset is asserted so no request is advertised during reset.
        req_ready = rst_n;
        if (req_valid) begin
          lat_addr_d = req_addr;
          lat_we_d   = req_we;
          replay_d   = 1'b0;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        cache_lookup = 1'b1;
`ifdef CACHE_MISS_PERF_EN
        if (!replay_q) begin
          if (cache_hit && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
          if (!cache_hit && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
        end
`endif
        word_cnt_d = '0;
        req_cnt_d  = '0;
        req_done_d = 1'b0;
        if (cache_hit) begin
          state_d = RESP;
        end else if (cache_victim_dirty) begin
          victim_line_d = cache_victim_tag_addr[ADDR_W-1:OFF_W];
          state_d       = WB;
        end else begin
          state_d = FILL;
        end
      end
      WB: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_addr      = {victim_line_q, word_cnt_q, 2'b00};
        cache_idx     = word_cnt_q;
        mem_wdata     = cache_rd_word;
        if (mem_req_ready) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == LAST) state_d = FILL;
        end
      end
      FILL: begin
        // Requests and returns are tracked separately so reads can run ahead of data.
        if (!req_done_q) begin
          mem_req_valid = 1'b1;
          mem_addr      = {lat_addr_q[ADDR_W-1:OFF_W], req_cnt_q, 2'b00};
          if (mem_req_ready) begin
            req_cnt_d = req_cnt_q + 1'b1;
            if (req_cnt_q == LAST) req_done_d = 1'b1;
          end
        end
        cache_idx = word_cnt_q;
        if (mem_rvalid) begin
          cache_fill_we   = 1'b1;
          cache_fill_data = mem_rdata;
          word_cnt_d      = word_cnt_q + 1'b1;
          if (word_cnt_q == LAST) begin
            replay_d = 1'b1;
            state_d  = LOOKUP;
          end
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      lat_addr_q    <= '0;
      lat_we_q      <= 1'b0;
      victim_line_q <= '0;
      word_cnt_q    <= '0;
      req_cnt_q     <= '0;
      req_done_q    <= 1'b0;
      replay_q      <= 1'b0;
`ifdef CACHE_MISS_PERF_EN
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      lat_addr_q    <= lat_addr_d;
      lat_we_q      <= lat_we_d;
      victim_line_q <= victim_line_d;
      word_cnt_q    <= word_cnt_d;
      req_cnt_q     <= req_cnt_d;
      req_done_q    <= req_done_d;
      replay_q      <= replay_d;
`ifdef CACHE_MISS_PERF_EN
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
`endif
    end
  end

endmodule

// File: doc/cache_miss_ctrl.md
CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 Parameter LINE_WORDS, default 4, words per cache line; legal values 2, 4 or 8.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-005 req_valid/req_ready  in/out  1/1  CPU request handshake; transfer when both high.
REQ-006 req_addr  in  ADDR_W  byte address; req_we  in  1  store when high.
REQ-007 resp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-008 cache_lookup  out  1  strobe to the 2-way LRU cache: perform tag compare and hit access for lat_addr/lat_we.
REQ-009 cache_hit  in  1  combinational hit result, valid in the cycle cache_lookup is high.
REQ-010 cache_victim_dirty  in  1, cache_victim_tag_addr  in  ADDR_W  LRU victim state, valid with cache_hit low.
REQ-011 cache_rd_word  in  32  victim word at cache_idx; cache_fill_we  out  1; cache_idx  out  log2(LINE_WORDS); cache_fill_data  out  32.
REQ-012 mem_req_valid/mem_req_ready  out/in  1/1, mem_req_we  out  1, mem_addr  out  ADDR_W, mem_wdata  out  32  backing-memory word request.
REQ-013 mem_rvalid  in  1, mem_rdata  in  32  read return, in order, one word per pulse.

Function
REQ-014 States: IDLE, LOOKUP, WB, FILL, RESP; encoding implementer's choice.
REQ-015 req_ready SHALL be high only in IDLE; accepted req_addr/req_we latched into lat_addr/lat_we.
REQ-016 IDLE -> LOOKUP on handshake; cache_lookup SHALL be high exactly in LOOKUP.
REQ-017 LOOKUP: hit -> RESP; miss and victim dirty -> WB; miss and clean -> FILL.
REQ-018 Hit latency: handshake in cycle N, resp_valid in cycle N+2.
REQ-019 WB: issue LINE_WORDS write requests, mem_addr = victim line base + 4*k, mem_wdata = cache_rd_word at cache_idx = k; k advances only on mem_req_valid && mem_req_ready; after last accepted write -> FILL.
REQ-020 FILL: issue LINE_WORDS read requests at lat_addr line base + 4*k; on each mem_rvalid assert cache_fill_we with cache_fill_data = mem_rdata at the return's word index; read requests may run ahead of returns by at most LINE_WORDS.
REQ-021 After the last fill word written -> LOOKUP (replay); replay SHALL hit; cache_lookup not asserted in WB/FILL.
REQ-022 RESP lasts one cycle with resp_valid high, then IDLE; back-to-back requests accepted every 3 cycles on hits.
REQ-023 Word counters SHALL wrap to 0 after LINE_WORDS-1; line base = addr with low log2(LINE_WORDS)+2 bits cleared.
REQ-024 mem_req_valid SHALL remain high with stable addr/data until accepted.
REQ-025 mem_rvalid outside FILL SHALL be ignored.

Reset
REQ-026 rst_n low at a rising edge SHALL force IDLE, counters 0, and all outputs low (req_ready high from the first cycle after reset release) regardless of state, including mid-WB or mid-FILL; abandoned memory transactions are not completed.

Configuration
REQ-027 Macro CACHE_MISS_PERF_EN: when defined, add outputs hit_cnt and miss_cnt (32 bits each), incremented in LOOKUP on first lookup only (replays not counted), saturating at 0xFFFFFFFF, cleared by reset; when undefined, the ports and counters SHALL not exist and behaviour is otherwise identical.

Verification
REQ-028 Read 0x0000_0000, cache_hit=1 -> cache_lookup at N+1, resp_valid at N+2, no mem_req_valid.
REQ-029 Read 0x0000_1000, miss clean -> 4 reads at 0x1000, 0x1004, 0x1008, 0x100C; fill_we at idx 0..3 with mem_rdata; replay lookup; one resp_valid.
REQ-030 Store 0x0000_2004, miss with victim dirty at 0x0000_0000 -> 4 writes at 0x0..0xC before any read of 0x2000..0x200C.
REQ-031 mem_req_ready held low 5 cycles during WB -> mem_addr/mem_wdata stable, counter frozen, no word lost.
REQ-032 rst_n low in second FILL cycle -> next cycle IDLE, outputs low; following hit request completes in 2 cycles.
REQ-033 With CACHE_MISS_PERF_EN: one hit and one miss -> hit_cnt=1, miss_cnt=1 after both responses.
